// File: rtl/deser160_pkg.sv
// Shared types and constants for the deser160 DMA write path.
package deser160_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } dma_state_e;

    localparam int HALF_W    = 16;
    localparam int WORD_W    = 32;
    localparam int ADDR_STEP = 4;

    // First-arriving half-word lands in the low half of the packed word.
    function automatic logic [WORD_W-1:0] pack_words(input logic [HALF_W-1:0] hi,
                                                     input logic [HALF_W-1:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/deser160_dma_if.sv
// Avalon-MM-style write-master bus between the DMA and DAQ memory.
interface deser160_dma_if #(
    parameter int ADDR_W = 25
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic              avm_waitrequest;

    modport master (
        output avm_address,
        output avm_write,
        output avm_writedata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_write,
        input  avm_writedata,
        output avm_waitrequest
    );
endinterface

// File: rtl/deser160_dma_fifo.sv
// Synchronous FIFO with registered occupancy count; a push on a full FIFO
// is accepted only when a pop frees the head slot in the same cycle.
module deser160_dma_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == (AW+1)'(0));
    assign level     = count_q;
    assign dout      = mem_q[rptr_q];
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Pointer and occupancy next-state.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clr) begin
            wptr_d  = AW'(0);
            rptr_d  = AW'(0);
            count_d = (AW+1)'(0);
        end else begin
            if (do_push_s) begin
                wptr_d = wptr_q + AW'(1);
            end else begin
                wptr_d = wptr_q;
            end
            if (do_pop_s) begin
                rptr_d = rptr_q + AW'(1);
            end else begin
                rptr_d = rptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= AW'(0);
            rptr_q  <= AW'(0);
            count_q <= (AW+1)'(0);
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are only meaningful below the count.
    always_ff @(posedge clk) begin
        if (do_push_s && !clr) begin
            mem_q[wptr_q] <= din;
        end
    end

endmodule

// File: rtl/deser160_dma.sv
// Packs 16-bit deserializer words into 32-bit words and writes them to a
// memory ring. Optional statistics ports under `DESER160_DMA_STATS_EN.
module deser160_dma
    import deser160_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 25
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              enable,
    input  logic              flush,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] top_addr,
    input  logic              din_write,
    input  logic [HALF_W-1:0] din,
    deser160_dma_if.master    avm,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              overflow,
    output logic              busy
`ifdef DESER160_DMA_STATS_EN
    ,
    output logic [15:0]       drop_count,
    output logic [31:0]       word_count
`endif
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    dma_state_e        state_q, state_d;
    logic [HALF_W-1:0] low_q, low_d;
    logic              half_q, half_d;
    logic              abort_q, abort_d;
    logic              overflow_q, overflow_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] avm_address_q, avm_address_d;
    logic              avm_write_q, avm_write_d;
    logic [WORD_W-1:0] avm_writedata_q, avm_writedata_d;

    logic              in_word_s, push_s, pop_s, drop_s, complete_s;
    logic [WORD_W-1:0] push_data_s, fifo_dout_s;
    logic              fifo_full_s, fifo_empty_s;
    logic [LW-1:0]     fifo_level_s;
    logic [ADDR_W-1:0] ptr_adv_s;

    assign in_word_s  = din_write & enable & ~start;
    assign complete_s = (state_q == WRITE) & ~avm.avm_waitrequest;
    // A transfer interrupted by start finishes but must not reload from the cleared FIFO.
    assign pop_s      = ~fifo_empty_s & ~start &
                        ((state_q == IDLE) | (complete_s & ~abort_q));
    assign drop_s     = push_s & fifo_full_s & ~pop_s;
    assign ptr_adv_s  = (wr_ptr_q == top_addr) ? base_addr
                                               : wr_ptr_q + ADDR_W'(ADDR_STEP);

    deser160_dma_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (start),
        .push    (push_s),
        .pop     (pop_s),
        .din     (push_data_s),
        .dout    (fifo_dout_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (fifo_level_s)
    );

    // Half-word packer and flush padding.
    always_comb begin
        low_d       = low_q;
        half_d      = half_q;
        push_s      = 1'b0;
        push_data_s = {WORD_W{1'b0}};
        if (start) begin
            half_d = 1'b0;
        end else if (in_word_s && half_q) begin
            push_s      = 1'b1;
            push_data_s = pack_words(din, low_q);
            half_d      = 1'b0;
        end else if (in_word_s && flush) begin
            push_s      = 1'b1;
            push_data_s = pack_words(16'h0000, din);
        end else if (in_word_s) begin
            low_d  = din;
            half_d = 1'b1;
        end else if (flush && half_q) begin
            push_s      = 1'b1;
            push_data_s = pack_words(16'h0000, low_q);
            half_d      = 1'b0;
        end else begin
            half_d = half_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = pop_s ? WRITE : IDLE;
            WRITE: begin
                if (complete_s) begin
                    state_d = pop_s ? WRITE : IDLE;
                end else begin
                    state_d = WRITE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: master bus, ring pointer, abort and overflow flags.
    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        avm_address_d   = avm_address_q;
        avm_write_d     = avm_write_q;
        avm_writedata_d = avm_writedata_q;
        abort_d         = abort_q;
        if (complete_s) begin
            avm_write_d = 1'b0;
            abort_d     = 1'b0;
            wr_ptr_d    = abort_q ? wr_ptr_q : ptr_adv_s;
        end else begin
            abort_d = abort_q;
        end
        if (pop_s) begin
            avm_write_d     = 1'b1;
            avm_address_d   = wr_ptr_d;
            avm_writedata_d = fifo_dout_s;
        end else begin
            avm_address_d = avm_address_q;
        end
        if (start) begin
            wr_ptr_d = base_addr;
            if ((state_q == WRITE) && !complete_s) begin
                abort_d = 1'b1;
            end else begin
                abort_d = 1'b0;
            end
        end else begin
            wr_ptr_d = wr_ptr_d;
        end
        overflow_d = start ? 1'b0 : (overflow_q | drop_s);
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            low_q           <= {HALF_W{1'b0}};
            half_q          <= 1'b0;
            abort_q         <= 1'b0;
            overflow_q      <= 1'b0;
            wr_ptr_q        <= {ADDR_W{1'b0}};
            avm_address_q   <= {ADDR_W{1'b0}};
            avm_write_q     <= 1'b0;
            avm_writedata_q <= {WORD_W{1'b0}};
        end else begin
            low_q           <= low_d;
            half_q          <= half_d;
            abort_q         <= abort_d;
            overflow_q      <= overflow_d;
            wr_ptr_q        <= wr_ptr_d;
            avm_address_q   <= avm_address_d;
            avm_write_q     <= avm_write_d;
            avm_writedata_q <= avm_writedata_d;
        end
    end

    assign avm.avm_address   = avm_address_q;
    assign avm.avm_write     = avm_write_q;
    assign avm.avm_writedata = avm_writedata_q;
    assign wr_ptr            = wr_ptr_q;
    assign overflow          = overflow_q;
    assign busy              = (fifo_level_s != {LW{1'b0}}) | avm_write_q | half_q;

`ifdef DESER160_DMA_STATS_EN
    logic [15:0] drop_count_q, drop_count_d;
    logic [31:0] word_count_q, word_count_d;

    // Drop counter saturates; write counter wraps.
    always_comb begin
        drop_count_d = drop_count_q;
        word_count_d = word_count_q;
        if (start) begin
            drop_count_d = 16'h0000;
            word_count_d = 32'h0000_0000;
        end else begin
            if (drop_s && (drop_count_q != 16'hFFFF)) begin
                drop_count_d = drop_count_q + 16'h0001;
            end else begin
                drop_count_d = drop_count_q;
            end
            if (complete_s) begin
                word_count_d = word_count_q + 32'h0000_0001;
            end else begin
                word_count_d = word_count_q;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count_q <= 16'h0000;
            word_count_q <= 32'h0000_0000;
        end else begin
            drop_count_q <= drop_count_d;
            word_count_q <= word_count_d;
        end
    end

    assign drop_count = drop_count_q;
    assign word_count = word_count_q;
`endif

endmodule

// File: doc/deser160_dma.md
# deser160_dma

Downstream of the deserializer: consumes the 16-bit `write`/`data` word stream, packs pairs of words into 32-bit words, buffers them in a small FIFO, and writes them into a ring buffer in DAQ memory through an Avalon-MM-style write master. It also provides a write pointer and an overflow flag for software readout.

## Interface
- `FIFO_DEPTH`, default 16: packed-word FIFO depth; power of two, at least 4.
- `ADDR_W`, default 25: byte-address width of the memory master.
- `clk` in 1: system clock, same domain as the deserializer.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse. Loads the pointer from `base_addr`, clears the packer, FIFO and `overflow`.
- `enable` in 1: accept input words while high.
- `flush` in 1: one-cycle pulse. Emits a pending half-word padded with zeros.
- `base_addr` in ADDR_W: ring start, byte address, 4-aligned.
- `top_addr` in ADDR_W: last 32-bit word address of the ring, inclusive, 4-aligned, at or above `base_addr`.
- `din_write` in 1: input word strobe (deserializer `write`).
- `din` in 16: input word (deserializer `data`).
- `avm_address` out ADDR_W: write address.
- `avm_write` out 1: write request.
- `avm_writedata` out 32: write data.
- `avm_waitrequest` in 1: slave stall.
- `wr_ptr` out ADDR_W: address of the next word to be written.
- `overflow` out 1: sticky flag; a packed word was dropped.
- `busy` out 1: high while the FIFO is not empty, a write is pending, or a half-word is held.

## Operation
- Packer register `low[15:0]` with valid bit `half`.
  - `din_write & enable & !half`: `low <= din`, `half <= 1`.
  - `din_write & enable & half`: push `{din, low}` to the FIFO; `half <= 0`. The first word goes in bits 15:0.
  - `flush & half`, no input word: push `{16'h0000, low}`; `half <= 0`.
  - `flush` together with an input word and `!half`: push `{16'h0000, din}`.
  - `flush` together with an input word and `half`: normal pair push, no padding.
  - `flush & !half`, no input word: no effect.
- Push while the FIFO is full: the packed word is dropped, `overflow <= 1`, and the FIFO is unchanged.
- `enable` low: `din_write` is ignored; the packer state is held.
- Output FSM:
  - IDLE, FIFO not empty: register the FIFO head into `avm_writedata`, set `avm_address <= wr_ptr`, `avm_write <= 1`, pop, go to WRITE.
  - WRITE, `!avm_waitrequest`: the transfer completes. Then `wr_ptr <= (wr_ptr == top_addr) ? base_addr : wr_ptr + 4`. If the FIFO is not empty, reload immediately and stay in WRITE (back-to-back writes); otherwise `avm_write <= 0` and go to IDLE.
  - WRITE, `avm_waitrequest`: address and data held stable.
- `start`:
  - Synchronous clear of `half`, the FIFO and `overflow`; `wr_ptr <= base_addr`.
  - If the FSM is in WRITE, the current transfer still completes, then the FSM goes to IDLE without advancing `wr_ptr`.
  - Input arriving in the same cycle as `start` is discarded.
- Arithmetic: `wr_ptr + 4` is modulo 2^ADDR_W. The ring wrap occurs only at equality with `top_addr`.

## Timing
- Reset values:
  - `avm_write` 0, `avm_address` 0, `avm_writedata` 0.
  - `wr_ptr` 0, `overflow` 0, `busy` 0.
  - FSM in IDLE, FIFO empty, `half` 0.
- Asynchronous reset mid-transfer drops `avm_write` immediately.
- Latency: second input word at edge N enters the FIFO; `avm_write` goes high after edge N+1 (one cycle FIFO to master).
- Sustained throughput: one 32-bit write per cycle with `avm_waitrequest` low, which exceeds the maximum input rate.
- `overflow` is set on the edge of the dropped push.
- FIFO full and empty are evaluated on registered counts. Push and pop in the same cycle on a full FIFO is accepted: the pop frees the slot.

## Configuration
- `DESER160_DMA_STATS_EN` defined:
  - Adds output port `drop_count[15:0]`, which counts dropped packed words and saturates at 16'hFFFF.
  - Adds output `word_count[31:0]`, which counts completed memory writes and wraps.
  - Both counters are cleared by reset and by `start`.
- Not defined: neither port nor counter exists; the rest of the behaviour is identical.

## Structure
- Package `deser160_pkg`: FSM state enum (IDLE, WRITE), word constants (`HALF_W=16`, `WORD_W=32`, `ADDR_STEP=4`).
- One sub-module: `deser160_dma_fifo`, a synchronous FIFO. Parameters: depth and width. Ports: push/pop, full/empty, level.

## Test plan
- Pair packing: reset, `start` with `base_addr=0x100`, `top_addr=0x10C`; input 0x1111 then 0x2222 with `avm_waitrequest` low -> one write of 0x22221111 at 0x100; `wr_ptr=0x104`.
- Flush padding: input 0xABCD, then a `flush` pulse -> write of 0x0000ABCD; `busy` returns to 0.
- Wrap-around: 10 input words into the same ring -> writes at 0x100, 0x104, 0x108, 0x10C, 0x100; `wr_ptr=0x104`.
- Stall and overflow: hold `avm_waitrequest` high and stream 2×(FIFO_DEPTH+2)+2 input words -> `overflow`=1; after release, the memory holds the first FIFO_DEPTH+1 words in order with address/data stable during the stall.
- `start` mid-transfer: `start` while WRITE is stalled -> the pending write completes at its old address; the next write goes to `base_addr`; `overflow` is cleared.
- Flush simultaneous with input (`half`=0), input 0x5555 -> single write of 0x00005555.
